// File: rtl/jump_pc_unit.sv
// jump_pc_unit: program counter with conditional-jump evaluation and a
// single-cycle flush bubble after each taken jump. A taken jump sets pc to
// a_reg and discards the one instruction already fetched behind it.
module jump_pc_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             is_c_instr,
    input  logic [2:0]       jump_bits,
    input  logic             alu_zr,
    input  logic             alu_ng,
    input  logic [WIDTH-1:0] a_reg,
    output logic [WIDTH-1:0] pc,
    output logic             flush,
    output logic             jump_taken,
    output logic [15:0]      jump_count
);

    // RUN: normal sequential fetch. FLUSH: the instruction fetched behind a
    // taken jump is in flight and must be discarded.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             jump_taken_q, jump_taken_d;
    logic [15:0]      jump_count_q, jump_count_d;

    logic             pos;
    logic             jump_cond;
    logic             take;

    // Decode the jump field against the ALU flags and qualify it into a take.
    always_comb begin
        pos       = ~alu_ng & ~alu_zr;
        jump_cond = (jump_bits[2] & alu_ng) |
                    (jump_bits[1] & alu_zr) |
                    (jump_bits[0] & pos);
        // A request seen while flushing is dropped, never remembered.
        take      = en & is_c_instr & jump_cond & (state_q == RUN);
    end

    // Next-state, next-pc, pulse and counter logic.
    always_comb begin
        // NOTE: every variable gets a hold/default value first so no path
        // through the case statement can leave it unassigned and infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        jump_taken_d = take;
        jump_count_d = jump_count_q;

        unique case (state_q)
            RUN: begin
                if (take) begin
                    pc_d    = a_reg;
                    state_d = FLUSH;
                end else if (en) begin
                    pc_d = pc_q + WIDTH'(1);
                end
            end
            FLUSH: begin
                // Jump condition deliberately ignored here.
                if (en) begin
                    pc_d    = pc_q + WIDTH'(1);
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (take && (jump_count_q != 16'hFFFF)) begin
            jump_count_d = jump_count_q + 16'd1;
        end
    end

    // State registers; reset clears everything at once, aborting any flush
    // or pulse in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample their inputs from the same pre-edge values.
        if (!rst_n) begin
            state_q      <= RUN;
            pc_q         <= '0;
            jump_taken_q <= 1'b0;
            jump_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            jump_taken_q <= jump_taken_d;
            jump_count_q <= jump_count_d;
        end
    end

    // Outputs come straight from flops; flush has no input-to-output path.
    always_comb begin
        pc         = pc_q;
        flush      = (state_q == FLUSH);
        jump_taken = jump_taken_q;
        jump_count = jump_count_q;
    end

endmodule

// File: tb/tb_jump_pc_unit.sv
// Self-checking bench for jump_pc_unit against a behavioural model that
// classifies the ALU result as lt/eq/gt and jumps when that class's bit is set.
module tb_jump_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        is_c_instr;
    logic [2:0]  jump_bits;
    logic        alu_zr;
    logic        alu_ng;
    logic [15:0] a_reg;
    logic [15:0] pc;
    logic        flush;
    logic        jump_taken;
    logic [15:0] jump_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_pc;
    bit          m_flush;
    bit          m_jt;
    int          m_count;

    jump_pc_unit #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .is_c_instr (is_c_instr),
        .jump_bits  (jump_bits),
        .alu_zr     (alu_zr),
        .alu_ng     (alu_ng),
        .a_reg      (a_reg),
        .pc         (pc),
        .flush      (flush),
        .jump_taken (jump_taken),
        .jump_count (jump_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result class: 2 = less than zero, 1 = zero, 0 = greater than zero.
    function automatic bit ref_cond(input bit [2:0] bits, input bit zr, input bit ng);
        int rel;
        rel = ng ? 2 : (zr ? 1 : 0);
        return bits[rel];
    endfunction

    function automatic void model_reset();
        m_pc    = 16'h0000;
        m_flush = 1'b0;
        m_jt    = 1'b0;
        m_count = 0;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, sample #1 later.
    task automatic step(input bit e, input bit c, input bit [2:0] b,
                        input bit zr, input bit ng, input logic [15:0] a);
        en = e; is_c_instr = c; jump_bits = b; alu_zr = zr; alu_ng = ng; a_reg = a;
        @(posedge clk);
        if (e) begin
            if (!m_flush && c && ref_cond(b, zr, ng)) begin
                m_pc    = a;
                m_flush = 1'b1;
                m_jt    = 1'b1;
                if (m_count < 65535) m_count++;
            end else begin
                m_pc    = 16'((int'(m_pc) + 1) % 65536);
                m_flush = 1'b0;
                m_jt    = 1'b0;
            end
        end else begin
            m_jt = 1'b0;
        end
        #1;
    endtask

    task automatic idle(input bit e);
        step(e, 1'b0, 3'b000, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0; is_c_instr = 1'b0; jump_bits = 3'b000;
        alu_zr = 1'b0; alu_ng = 1'b0; a_reg = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (pc !== 16'h0000) begin n_err++; $display("FAIL reset_pc: got %h want 0000", pc); end
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %b want 0", flush); end
        n_cmp++; if (jump_taken !== 1'b0) begin n_err++; $display("FAIL reset_jt: got %b want 0", jump_taken); end
        n_cmp++; if (jump_count !== 16'h0000) begin n_err++; $display("FAIL reset_count: got %h want 0000", jump_count); end
        #2 rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 4; i++) begin
            idle(1'b1);
            n_cmp++; if (pc !== 16'(i)) begin n_err++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, 16'(i)); end
            n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL seq_flush[%0d]: got %b want 0", i, flush); end
        end
        n_cmp++; if (jump_count !== 16'h0000) begin n_err++; $display("FAIL seq_count: got %h want 0000", jump_count); end
    endtask

    task automatic test_jump();
        idle(1'b1); // pc = 5
        n_cmp++; if (pc !== 16'h0005) begin n_err++; $display("FAIL jump_pre_pc: got %h want 0005", pc); end
        step(1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 16'h0040);
        n_cmp++; if (pc !== 16'h0040) begin n_err++; $display("FAIL jump_pc: got %h want 0040", pc); end
        n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL jump_flush: got %b want 1", flush); end
        n_cmp++; if (jump_taken !== 1'b1) begin n_err++; $display("FAIL jump_jt: got %b want 1", jump_taken); end
        n_cmp++; if (jump_count !== 16'h0001) begin n_err++; $display("FAIL jump_count: got %h want 0001", jump_count); end
        idle(1'b1);
        n_cmp++; if (pc !== 16'h0041) begin n_err++; $display("FAIL jump_next_pc: got %h want 0041", pc); end
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL jump_next_flush: got %b want 0", flush); end
        n_cmp++; if (jump_taken !== 1'b0) begin n_err++; $display("FAIL jump_next_jt: got %b want 0", jump_taken); end
    endtask

    task automatic test_flush_drop();
        step(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0100);
        step(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0200); // request during FLUSH
        n_cmp++; if (pc !== 16'h0101) begin n_err++; $display("FAIL drop_pc: got %h want 0101", pc); end
        n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL drop_flush: got %b want 0", flush); end
        n_cmp++; if (jump_taken !== 1'b0) begin n_err++; $display("FAIL drop_jt: got %b want 0", jump_taken); end
        n_cmp++; if (jump_count !== 16'h0002) begin n_err++; $display("FAIL drop_count: got %h want 0002", jump_count); end
    endtask

    task automatic test_self_target();
        logic [15:0] here;
        here = m_pc;
        step(1'b1, 1'b1, 3'b111, 1'b1, 1'b0, here);
        n_cmp++; if (pc !== here) begin n_err++; $display("FAIL self_pc: got %h want %h", pc, here); end
        n_cmp++; if (jump_taken !== 1'b1) begin n_err++; $display("FAIL self_jt: got %b want 1", jump_taken); end
        idle(1'b1);
    endtask

    task automatic test_cond_table();
        bit zr, ng, exp_take;
        for (int b = 0; b < 8; b++) begin
            for (int f = 0; f < 3; f++) begin
                zr = (f == 0);
                ng = (f == 1);
                if (m_flush) idle(1'b1);
                exp_take = ref_cond(3'(b), zr, ng);
                step(1'b1, 1'b1, 3'(b), zr, ng, 16'($urandom));
                n_cmp++;
                if (jump_taken !== exp_take || pc !== m_pc) begin
                    n_err++;
                    $display("FAIL cond_table b=%03b zr=%b ng=%b: jt=%b pc=%h want jt=%b pc=%h",
                             3'(b), zr, ng, jump_taken, pc, exp_take, m_pc);
                end
            end
        end
        // is_c_instr low suppresses even an unconditional jump field
        if (m_flush) idle(1'b1);
        step(1'b1, 1'b0, 3'b111, 1'b0, 1'b1, 16'h1234);
        n_cmp++; if (jump_taken !== 1'b0 || flush !== 1'b0) begin
            n_err++; $display("FAIL not_c_instr: jt=%b flush=%b want 0 0", jump_taken, flush);
        end
        // Randomised run compared every cycle against the model.
        for (int i = 0; i < 128; i++) begin
            int sel;
            sel = $urandom_range(0, 2);
            step($urandom_range(0, 3) != 0, 1'($urandom), 3'($urandom),
                 sel == 0, sel == 1, 16'($urandom));
            n_cmp++;
            if (pc !== m_pc || flush !== m_flush || jump_taken !== m_jt || jump_count !== 16'(m_count)) begin
                n_err++;
                $display("FAIL random[%0d]: pc=%h fl=%b jt=%b cnt=%h want pc=%h fl=%b jt=%b cnt=%h",
                         i, pc, flush, jump_taken, jump_count, m_pc, m_flush, m_jt, 16'(m_count));
                $fatal(1, "random stimulus diverged from model");
            end
        end
    endtask

    task automatic test_wrap_hold();
        logic [15:0] cnt;
        if (m_flush) idle(1'b1);
        step(1'b1, 1'b1, 3'b111, 1'b0, 1'b0, 16'hFFFE);
        idle(1'b1);
        n_cmp++; if (pc !== 16'hFFFF) begin n_err++; $display("FAIL wrap_pre_pc: got %h want ffff", pc); end
        idle(1'b1);
        n_cmp++; if (pc !== 16'h0000) begin n_err++; $display("FAIL wrap_pc: got %h want 0000", pc); end
        step(1'b1, 1'b1, 3'b001, 1'b0, 1'b0, 16'h0010);
        cnt = jump_count;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 3'b111, 1'b0, 1'b0, 16'h0777);
            n_cmp++;
            if (pc !== 16'h0010 || flush !== 1'b1 || jump_taken !== 1'b0 || jump_count !== cnt) begin
                n_err++;
                $display("FAIL hold[%0d]: pc=%h fl=%b jt=%b cnt=%h want pc=0010 fl=1 jt=0 cnt=%h",
                         i, pc, flush, jump_taken, jump_count, cnt);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        idle(1'b1);
        step(1'b1, 1'b1, 3'b100, 1'b0, 1'b1, 16'h0020);
        n_cmp++; if (flush !== 1'b1 || jump_taken !== 1'b1) begin
            n_err++; $display("FAIL mid_pre: flush=%b jt=%b want 1 1", flush, jump_taken);
        end
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (pc !== 16'h0000 || flush !== 1'b0 || jump_taken !== 1'b0 || jump_count !== 16'h0000) begin
            n_err++;
            $display("FAIL async_reset: pc=%h fl=%b jt=%b cnt=%h want all zero", pc, flush, jump_taken, jump_count);
        end
        #1 rst_n = 1'b1;
        idle(1'b1);
        n_cmp++;
        if (pc !== 16'h0001 || flush !== 1'b0 || jump_taken !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: pc=%h fl=%b jt=%b want 0001 0 0", pc, flush, jump_taken);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_flush_drop();
        test_self_target();
        test_cond_table();
        test_wrap_hold();
        test_reset_mid_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
